servo_angle_tracker: RTL and testbench

//  Produces the angle command consumed by the servo PWM generator: scans the servo across its range,

---
 rtl/servo_angle_tracker.sv | 186 ++++++++++++++++++
 tb/tb_servo_angle_tracker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/servo_angle_tracker.sv
// Servo angle command generator: parks at center, sweeps the range, then
// steers toward an IR source seen by left/right detectors. The angle changes
// at most once per frame so the PWM stage sees one value per pulse period.
module servo_angle_tracker #(
  parameter int unsigned FRAME_CYCLES = 2_000_000,
  parameter int unsigned ANGLE_MIN    = 0,
  parameter int unsigned ANGLE_MAX    = 180,
  parameter int unsigned ANGLE_CENTER = 90,
  parameter int unsigned SCAN_STEP    = 2,
  parameter int unsigned TRACK_STEP   = 1,
  parameter int unsigned LOST_FRAMES  = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        ir_left,
  input  logic        ir_right,
  output logic [15:0] angle,
  output logic        frame_tick,
  output logic [1:0]  state,
  output logic        locked
);

  localparam int unsigned CNT_W  = $clog2(FRAME_CYCLES);
  localparam int unsigned LOST_W = $clog2(LOST_FRAMES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [LOST_W-1:0] LOST_LAST = LOST_W'(LOST_FRAMES - 1);
  localparam logic [15:0] MIN16    = 16'(ANGLE_MIN);
  localparam logic [15:0] MAX16    = 16'(ANGLE_MAX);
  localparam logic [15:0] CENTER16 = 16'(ANGLE_CENTER);
  localparam logic [16:0] SSTEP17  = 17'(SCAN_STEP);
  localparam logic [16:0] TSTEP17  = 17'(TRACK_STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    TRACK = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [LOST_W-1:0]   lost_q, lost_d;
  logic [15:0]         angle_q, angle_d;
  logic                dir_up_q, dir_up_d;
  logic                locked_q, locked_d;
  logic                l_meta_q, l_q, r_meta_q, r_q;
  logic                tick;
  logic                up_hit, dn_hit;
  logic [15:0]         park_angle;

  // Saturating add: clamps to lim when the 17-bit sum reaches or passes it.
  function automatic logic [15:0] step_up(input logic [15:0] a,
                                          input logic [16:0] step,
                                          input logic [15:0] lim);
    logic [16:0] s;
    s = {1'b0, a} + step;
    return (s >= {1'b0, lim}) ? lim : s[15:0];
  endfunction

  // Saturating subtract: a borrow out of bit 16 also clamps to lim.
  function automatic logic [15:0] step_dn(input logic [15:0] a,
                                          input logic [16:0] step,
                                          input logic [15:0] lim);
    logic [16:0] d;
    d = {1'b0, a} - step;
    return (d[16] || (d <= {1'b0, lim})) ? lim : d[15:0];
  endfunction

  assign tick = (cnt_q == CNT_LAST);

  // Two-stage synchronizers for the asynchronous IR detectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_meta_q <= 1'b0;
      l_q      <= 1'b0;
      r_meta_q <= 1'b0;
      r_q      <= 1'b0;
    end else begin
      l_meta_q <= ir_left;
      l_q      <= l_meta_q;
      r_meta_q <= ir_right;
      r_q      <= r_meta_q;
    end
  end

  // Frame counter: 0..FRAME_CYCLES-1, tick on the last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      angle_q  <= CENTER16;
      dir_up_q <= 1'b1;
      lost_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      angle_q  <= angle_d;
      dir_up_q <= dir_up_d;
      lost_q   <= lost_d;
      locked_q <= locked_d;
    end
  end

  // Next-state: leaving SCAN/TRACK on enable low does not wait for a tick.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (tick && enable) state_d = SCAN;
      SCAN:  begin
        if (!enable)                   state_d = IDLE;
        else if (tick && (l_q || r_q)) state_d = TRACK;
      end
      TRACK: begin
        if (!enable) state_d = IDLE;
        else if (tick && !l_q && !r_q && (lost_q == LOST_LAST)) state_d = SCAN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Angle, sweep direction, lost counter and lock flag for each state.
  always_comb begin
    angle_d    = angle_q;
    dir_up_d   = dir_up_q;
    lost_d     = lost_q;
    locked_d   = locked_q;
    up_hit     = ({1'b0, angle_q} + SSTEP17) >= {1'b0, MAX16};
    dn_hit     = (angle_q <= MIN16) ||
                 (({1'b0, angle_q} - SSTEP17) <= {1'b0, MIN16});
    park_angle = (angle_q > CENTER16) ? step_dn(angle_q, SSTEP17, CENTER16)
                                      : step_up(angle_q, SSTEP17, CENTER16);
    unique case (state_q)
      IDLE: begin
        locked_d = 1'b0;
        lost_d   = '0;
        if (tick) angle_d = park_angle;
      end
      SCAN: begin
        locked_d = 1'b0;
        if (!enable) begin
          lost_d = '0;
          if (tick) angle_d = park_angle;
        end else if (tick) begin
          if (l_q || r_q) begin
            lost_d = '0;
          end else if (dir_up_q) begin
            angle_d = step_up(angle_q, SSTEP17, MAX16);
            if (up_hit) dir_up_d = 1'b0;
          end else begin
            angle_d = step_dn(angle_q, SSTEP17, MIN16);
            if (dn_hit) dir_up_d = 1'b1;
          end
        end
      end
      TRACK: begin
        if (!enable) begin
          locked_d = 1'b0;
          lost_d   = '0;
          if (tick) angle_d = park_angle;
        end else if (tick) begin
          locked_d = l_q && r_q;
          lost_d   = '0;
          if (l_q && !r_q)      angle_d = step_dn(angle_q, TSTEP17, MIN16);
          else if (!l_q && r_q) angle_d = step_up(angle_q, TSTEP17, MAX16);
          else if (!l_q && !r_q && (lost_q != LOST_LAST))
            lost_d = lost_q + LOST_W'(1);
        end
      end
      default: locked_d = 1'b0;
    endcase
  end

  // Outputs straight from registers.
  always_comb begin
    angle      = angle_q;
    state      = state_q;
    locked     = locked_q;
    frame_tick = tick;
  end

endmodule

// File: tb/tb_servo_angle_tracker.sv
// Directed bench for servo_angle_tracker with a 10-cycle frame.
module tb_servo_angle_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        ir_left;
  logic        ir_right;
  logic [15:0] angle;
  logic        frame_tick;
  logic [1:0]  state;
  logic        locked;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  servo_angle_tracker #(
    .FRAME_CYCLES(10),
    .ANGLE_MIN(0),
    .ANGLE_MAX(180),
    .ANGLE_CENTER(90),
    .SCAN_STEP(2),
    .TRACK_STEP(1),
    .LOST_FRAMES(25)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .ir_left(ir_left),
    .ir_right(ir_right),
    .angle(angle),
    .frame_tick(frame_tick),
    .state(state),
    .locked(locked)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance until a cycle with frame_tick high; n = clock edges taken.
  task automatic find_tick(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!frame_tick && n < 40);
    if (!frame_tick) check("tick_timeout", {31'd0, frame_tick}, 32'd1);
  endtask

  // Advance past the next tick so its update is visible.
  task automatic next_tick();
    int n;
    find_tick(n);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; enable = 1'b0; ir_left = 1'b0; ir_right = 1'b0;
    #12;
    check("rst_angle", angle, 90);
    check("rst_state", state, 0);
    check("rst_tick", frame_tick, 0);
    check("rst_locked", locked, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle frame timing and parking at center.
    find_tick(n);
    check("first_tick_cycle", n, 9);
    find_tick(n);
    check("tick_period", n, 10);
    @(posedge clk); #1;
    check("idle_angle", angle, 90);
    check("idle_state", state, 0);
    check("idle_locked", locked, 0);

    // Sweep: one IDLE tick, then +2 per tick, flipping at 180.
    enable = 1'b1;
    next_tick();
    check("scan_enter_state", state, 1);
    check("scan_enter_angle", angle, 90);
    for (int k = 1; k <= 60; k++) begin
      next_tick();
      check($sformatf("sweep_%0d", k), angle, (k <= 45) ? 90 + 2 * k : 180 - 2 * (k - 45));
    end
    for (int k = 1; k <= 25; k++) next_tick();
    check("sweep_down_100", angle, 100);
    check("sweep_down_state", state, 1);

    // Acquire on the right detector and step toward it, then lock.
    ir_right = 1'b1;
    next_tick();
    check("acq_state", state, 2);
    check("acq_angle", angle, 100);
    check("acq_locked", locked, 0);
    next_tick();
    check("track_r1", angle, 101);
    next_tick();
    check("track_r2", angle, 102);
    ir_left = 1'b1;
    next_tick();
    check("lock_angle", angle, 102);
    check("lock_flag", locked, 1);
    check("lock_state", state, 2);

    // Loss of IR: frozen for 24 ticks, a sub-frame glitch is ignored.
    ir_left = 1'b0; ir_right = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      if (k == 5) begin
        repeat (2) begin @(posedge clk); #1; end
        ir_left = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        ir_left = 1'b0;
      end
      next_tick();
      check($sformatf("lost_angle_%0d", k), angle, 102);
      check($sformatf("lost_state_%0d", k), state, 2);
    end
    check("lost_unlocked", locked, 0);
    next_tick();
    check("lost_fallback_state", state, 1);
    check("lost_fallback_angle", angle, 102);
    next_tick();
    check("rescan_dir_down", angle, 100);

    // Drive to 2, acquire on the left and saturate at 0.
    for (int k = 1; k <= 49; k++) next_tick();
    check("scan_to_2", angle, 2);
    ir_left = 1'b1;
    next_tick();
    check("acq_left_state", state, 2);
    check("acq_left_angle", angle, 2);
    next_tick();
    check("track_l_1", angle, 1);
    for (int k = 1; k <= 3; k++) begin
      next_tick();
      check($sformatf("track_l_sat_%0d", k), angle, 0);
    end
    ir_left = 1'b0;

    // Mid-frame reset restarts the frame.
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0; enable = 1'b0;
    #1;
    check("midrst_angle", angle, 90);
    check("midrst_state", state, 0);
    check("midrst_tick", frame_tick, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    enable = 1'b1;
    find_tick(n);
    check("midrst_first_tick", n, 9);
    @(posedge clk); #1;
    check("re_scan_state", state, 1);
    for (int k = 1; k <= 15; k++) next_tick();
    check("scan_to_120", angle, 120);
    ir_left = 1'b1; ir_right = 1'b1;
    next_tick();
    check("acq120_state", state, 2);
    check("acq120_angle", angle, 120);
    next_tick();
    check("lock120", locked, 1);

    // Enable drop mid-frame: IDLE at once, angle held, then parks.
    repeat (4) begin @(posedge clk); #1; end
    enable = 1'b0; ir_left = 1'b0; ir_right = 1'b0;
    @(posedge clk); #1;
    check("dis_state", state, 0);
    check("dis_locked", locked, 0);
    check("dis_angle_hold", angle, 120);
    for (int k = 1; k <= 15; k++) begin
      next_tick();
      check($sformatf("park_%0d", k), angle, 120 - 2 * k);
    end
    next_tick();
    check("park_center", angle, 90);

    // Enable falling on the tick cycle: IDLE wins, one park step.
    enable = 1'b1;
    next_tick();
    check("re_en_state", state, 1);
    check("re_en_angle", angle, 90);
    next_tick();
    check("re_en_92", angle, 92);
    next_tick();
    check("re_en_94", angle, 94);
    find_tick(n);
    enable = 1'b0;
    @(posedge clk); #1;
    check("tick_dis_state", state, 0);
    check("tick_dis_angle", angle, 92);
    next_tick();
    check("tick_dis_park", angle, 90);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
